// File: rtl/valve_sequencer_if.sv
// Controller-to-valve-stage signal bundle: water commands and error status in,
// valve drives and status flags out.
interface valve_sequencer_if;
    logic [1:0] R1;
    logic [1:0] R2;
    logic [1:0] E;
    logic [3:0] V;
    logic       busy;
    logic       fault;
    logic       alarm;
    logic [2:0] open_cnt;

    // Irrigation controller side (drives commands, observes valve stage).
    modport master (
        output R1, R2, E,
        input  V, busy, fault, alarm, open_cnt
    );

    // Valve sequencer side.
    modport slave (
        input  R1, R2, E,
        output V, busy, fault, alarm, open_cnt
    );
endinterface

// File: rtl/valve_sequencer.sv
// Valve sequencer: opens the four solenoid valves one at a time with a settle
// gap between openings, holds every opened valve for a minimum on-time, and
// closes everything with a blinking alarm while the controller reports error.
module valve_sequencer #(
    parameter int SETTLE_CYC = 4,
    parameter int MIN_ON_CYC = 8,
    parameter int BLINK_CYC  = 16
) (
    input  logic             clk,
    input  logic             reset,
    valve_sequencer_if.slave bus
);

    localparam int SW = $clog2(SETTLE_CYC);
    localparam int OW = $clog2(MIN_ON_CYC + 1);
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [OW-1:0] ON_SAT      = OW'(MIN_ON_CYC);
    // on_cnt reads MIN_ON_CYC-1 at the edge MIN_ON_CYC cycles after opening,
    // so comparing against that value closes the valve exactly on time.
    localparam logic [OW-1:0] ON_HOLD     = OW'(MIN_ON_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [3:0]      v_q, v_d;
    logic            busy_q, busy_d;
    logic            fault_q, fault_d;
    logic            alarm_q, alarm_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic [BW-1:0]   acnt_q, acnt_d;
    logic [OW-1:0]   on_cnt_q [4];
    logic [OW-1:0]   on_cnt_d [4];

    logic [3:0]      req;
    logic [3:0]      pending;
    logic [3:0]      first;
    logic [3:0]      open_sel;
    logic [3:0]      close_sel;
    logic            err;

    // Next-state, valve open/close decisions and counter updates.
    always_comb begin
        state_d   = state;
        v_d       = v_q;
        busy_d    = 1'b0;
        fault_d   = fault_q;
        alarm_d   = alarm_q;
        scnt_d    = scnt_q;
        acnt_d    = acnt_q;
        on_cnt_d  = on_cnt_q;
        open_sel  = '0;
        close_sel = '0;

        req     = {bus.R2, bus.R1};
        err     = (bus.E == 2'b00);
        pending = req & ~v_q;
        first   = pending & (~pending + 4'd1);

        for (int unsigned i = 0; i < 4; i++) begin
            close_sel[i] = v_q[i] & ~req[i] & (on_cnt_q[i] >= ON_HOLD);
        end

        if (err) begin
            state_d = FAULT;
            v_d     = '0;
            fault_d = 1'b1;
            if (state != FAULT) begin
                alarm_d = 1'b1;
                acnt_d  = '0;
            end else if (acnt_q == BLINK_LAST) begin
                alarm_d = ~alarm_q;
                acnt_d  = '0;
            end else begin
                acnt_d = acnt_q + 1'b1;
            end
        end else begin
            fault_d = 1'b0;
            alarm_d = 1'b0;
            acnt_d  = '0;
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        open_sel = first;
                        scnt_d   = SETTLE_LOAD;
                        state_d  = SETTLE;
                    end
                end
                SETTLE: begin
                    if (scnt_q != '0) begin
                        scnt_d = scnt_q - 1'b1;
                    end else if (pending != '0) begin
                        open_sel = first;
                        scnt_d   = SETTLE_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FAULT:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
            v_d = (v_q & ~close_sel) | open_sel;
        end

        for (int unsigned i = 0; i < 4; i++) begin
            if (open_sel[i]) begin
                on_cnt_d[i] = '0;
            end else if (v_q[i] && (on_cnt_q[i] != ON_SAT)) begin
                on_cnt_d[i] = on_cnt_q[i] + 1'b1;
            end
        end

        busy_d = (state_d == SETTLE) ||
                 ((state_d != FAULT) && ((req & ~v_d) != '0));
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            v_q     <= '0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            alarm_q <= 1'b0;
            scnt_q  <= '0;
            acnt_q  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                on_cnt_q[i] <= '0;
            end
        end else begin
            state    <= state_d;
            v_q      <= v_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
            alarm_q  <= alarm_d;
            scnt_q   <= scnt_d;
            acnt_q   <= acnt_d;
            on_cnt_q <= on_cnt_d;
        end
    end

    assign bus.V        = v_q;
    assign bus.busy     = busy_q;
    assign bus.fault    = fault_q;
    assign bus.alarm    = alarm_q;
    assign bus.open_cnt = {2'b00, v_q[0]} + {2'b00, v_q[1]} +
                          {2'b00, v_q[2]} + {2'b00, v_q[3]};

endmodule
